// File: rtl/mdio_master_param_if.sv
// Host-side bundle for the MDIO master: start/frame request, pad signals and read-back.
// The master modport is the controller's view; slave is the host/PHY-side view.
interface mdio_master_param_if;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic        MDC;
  logic [15:0] RD_DATA;
  logic        DATA_RDY;
  logic        BUSY;
  logic        ERR;

  modport master (
    input  MDIO_START, T_DATA, MDIO_IN,
    output MDIO_OUT, MDIO_OE, MDC, RD_DATA, DATA_RDY, BUSY, ERR
  );

  modport slave (
    output MDIO_START, T_DATA, MDIO_IN,
    input  MDIO_OUT, MDIO_OE, MDC, RD_DATA, DATA_RDY, BUSY, ERR
  );
endinterface

// File: rtl/mdio_master_param.sv
// Parametrised MDIO management master: preamble + 32-bit C22/C45 frame, MDC from a clk
// divider, read data captured on MDC rising edges and returned with a one-clk ready pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for MDIO_START; invalid requests pulse ERR here
// S_PRE    | driving PRE_LEN preamble ones
// S_FRAME  | shifting frame bits 31..0; pad released from bit 17 on reads
// S_FINISH | one cycle: pad released, DATA_RDY on reads, back to idle
module mdio_master_param #(
  parameter int CLK_DIV = 4,
  parameter int PRE_LEN = 32
) (
  input logic                 clk,
  input logic                 RESET,
  mdio_master_param_if.master bus
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam bit              HAS_PRE  = (PRE_LEN > 0);
  localparam logic [4:0]      PRE_LAST = HAS_PRE ? 5'(PRE_LEN - 1) : 5'd0;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_FRAME, S_FINISH} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_frame;
  logic              r_is_read;
  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_mdc;
  logic [4:0]        r_bit_cnt;
  logic [15:0]       r_rd_shift;
  logic [15:0]       r_rd_data;
  logic              r_err;

  logic [1:0]        w_st;
  logic [1:0]        w_op;
  logic              w_req_rd;
  logic              w_req_wr;
  logic              w_tick;
  logic              w_bit_end;
  logic              w_last_bit;
  logic              w_release;
  logic              w_busy;
  logic              w_oe;
  logic              w_out;
  logic              w_mdc;
  logic              w_rdy;

  always_comb begin
    w_st       = bus.T_DATA[31:30];
    w_op       = bus.T_DATA[29:28];
    w_req_rd   = ((w_st == 2'b01) && (w_op == 2'b10)) || ((w_st == 2'b00) && w_op[1]);
    w_req_wr   = ((w_st == 2'b01) && (w_op == 2'b01)) || ((w_st == 2'b00) && !w_op[1]);
    w_tick     = (r_div_cnt == '0);
    w_bit_end  = w_tick && r_mdc;
    w_last_bit = (r_bit_cnt == 5'd0);
    w_release  = r_is_read && (r_bit_cnt <= 5'd17);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_oe        = 1'b0;
    w_out       = 1'b0;
    w_mdc       = 1'b0;
    w_rdy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.MDIO_START && (w_req_rd || w_req_wr))
          w_state_nxt = HAS_PRE ? S_PRE : S_FRAME;
      end
      S_PRE: begin
        w_busy = 1'b1;
        w_oe   = 1'b1;
        w_out  = 1'b1;
        w_mdc  = r_mdc;
        if (w_bit_end && w_last_bit)
          w_state_nxt = S_FRAME;
      end
      S_FRAME: begin
        w_busy = 1'b1;
        w_oe   = !w_release;
        w_out  = w_release ? 1'b0 : r_frame[r_bit_cnt];
        w_mdc  = r_mdc;
        if (w_bit_end && w_last_bit)
          w_state_nxt = S_FINISH;
      end
      S_FINISH: begin
        w_rdy       = r_is_read;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_frame    <= '0;
      r_is_read  <= 1'b0;
      r_div_cnt  <= '0;
      r_mdc      <= 1'b0;
      r_bit_cnt  <= '0;
      r_rd_shift <= '0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.MDIO_START) begin
            if (w_req_rd || w_req_wr) begin
              r_frame   <= bus.T_DATA;
              r_is_read <= w_req_rd;
              r_div_cnt <= DIV_MAX;
              r_mdc     <= 1'b0;
              r_bit_cnt <= HAS_PRE ? PRE_LAST : 5'd31;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_PRE, S_FRAME: begin
          // PHY data is taken on the clk edge that raises MDC, bits 15..0 only.
          if ((r_state == S_FRAME) && r_is_read && !r_mdc && w_tick && (r_bit_cnt <= 5'd15))
            r_rd_shift <= {r_rd_shift[14:0], bus.MDIO_IN};
          if (w_tick) begin
            r_div_cnt <= DIV_MAX;
            r_mdc     <= ~r_mdc;
            if (r_mdc) begin
              if (w_last_bit) begin
                if (r_state == S_PRE)
                  r_bit_cnt <= 5'd31;
                else if (r_is_read)
                  r_rd_data <= r_rd_shift;
              end else begin
                r_bit_cnt <= r_bit_cnt - 5'd1;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.MDIO_OUT = w_out;
  assign bus.MDIO_OE  = w_oe;
  assign bus.MDC      = w_mdc;
  assign bus.BUSY     = w_busy;
  assign bus.DATA_RDY = w_rdy;
  assign bus.RD_DATA  = r_rd_data;
  assign bus.ERR      = r_err;

endmodule

// File: tb/tb_mdio_master_param.sv
// Directed bench for mdio_master_param: a CLK_DIV=2/PRE_LEN=32 instance for C22/C45 frames,
// invalid requests, restart and reset abort, plus a CLK_DIV=1/PRE_LEN=0 instance.
module tb_mdio_master_param;

  logic clk = 1'b0;
  logic RESET = 1'b0;
  always #5 clk = ~clk;

  mdio_master_param_if b0();
  mdio_master_param_if b1();

  mdio_master_param #(.CLK_DIV(2), .PRE_LEN(32)) u_dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (b0)
  );

  mdio_master_param #(.CLK_DIV(1), .PRE_LEN(0)) u_dut6 (
    .clk   (clk),
    .RESET (RESET),
    .bus   (b1)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic sel = 1'b0;

  logic        s_busy, s_oe, s_out, s_mdc, s_rdy, s_err;
  logic [15:0] s_rd;
  assign s_busy = sel ? b1.BUSY     : b0.BUSY;
  assign s_oe   = sel ? b1.MDIO_OE  : b0.MDIO_OE;
  assign s_out  = sel ? b1.MDIO_OUT : b0.MDIO_OUT;
  assign s_mdc  = sel ? b1.MDC      : b0.MDC;
  assign s_rdy  = sel ? b1.DATA_RDY : b0.DATA_RDY;
  assign s_err  = sel ? b1.ERR      : b0.ERR;
  assign s_rd   = sel ? b1.RD_DATA  : b0.RD_DATA;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic st, input logic [31:0] td);
    if (sel) begin
      b1.MDIO_START = st;
      b1.T_DATA     = td;
    end else begin
      b0.MDIO_START = st;
      b0.T_DATA     = td;
    end
  endtask

  task automatic set_mdio_in(input logic v);
    b0.MDIO_IN = v;
    b1.MDIO_IN = v;
  endtask

  task automatic run_frame(input string nm, input logic [31:0] td, input logic [15:0] phy,
                           input int pre, input int exp_busy, input bit is_rd,
                           input logic [15:0] exp_rd, input bit chk_tog);
    int busy_n, rises, rdy_n, oe_fall, pre_ones, notog, fb;
    bit seen, done, prev_mdc, prev_oe;
    logic [31:0] bits, oe_bits;
    logic first_out, fin_rdy;
    logic [15:0] fin_rd;
    busy_n = 0; rises = 0; rdy_n = 0; oe_fall = -1; pre_ones = 0; notog = 0;
    seen = 0; done = 0; prev_mdc = 0; prev_oe = 0;
    bits = '0; oe_bits = '0; first_out = 1'bx; fin_rdy = 1'bx; fin_rd = 'x;
    set_start(1'b1, td);
    @(negedge clk);
    set_start(1'b0, td);
    for (int g = 0; g < 4000 && !done; g++) begin
      if (s_rdy) rdy_n++;
      if (s_busy) begin
        if (!seen) first_out = s_out;
        if (seen && chk_tog && (s_mdc == prev_mdc)) notog++;
        if (seen && prev_oe && !s_oe) oe_fall = rises;
        if (seen && !prev_mdc && s_mdc) begin
          if (rises < pre) begin
            if (s_out && s_oe) pre_ones++;
          end else begin
            fb = 31 - (rises - pre);
            if (fb >= 0) begin
              bits[fb]    = s_out;
              oe_bits[fb] = s_oe;
            end
          end
          rises++;
        end
        if (!s_mdc) begin
          fb = 31 - (rises - pre);
          if ((rises >= pre) && (fb >= 0) && (fb <= 15)) set_mdio_in(phy[fb]);
          else set_mdio_in(1'b1);
        end
        busy_n++;
        seen     = 1;
        prev_mdc = s_mdc;
        prev_oe  = s_oe;
      end else if (seen) begin
        fin_rdy = s_rdy;
        fin_rd  = s_rd;
        done    = 1;
      end
      if (!done) @(negedge clk);
    end
    if (!done) check({nm, "_timeout"}, 32'd0, 32'd1);
    check({nm, "_busy_cycles"}, busy_n, exp_busy);
    check({nm, "_mdc_rises"}, rises, pre + 32);
    check({nm, "_preamble_ones"}, pre_ones, pre);
    check({nm, "_frame_bits"}, bits, is_rd ? (td & 32'hFFFC_0000) : td);
    check({nm, "_oe_bits"}, oe_bits, is_rd ? 32'hFFFC_0000 : 32'hFFFF_FFFF);
    check({nm, "_oe_fall"}, oe_fall, is_rd ? pre + 14 : -1);
    check({nm, "_first_out"}, {31'd0, first_out}, (pre > 0) ? 32'd1 : {31'd0, td[31]});
    check({nm, "_rdy_count"}, rdy_n, is_rd ? 1 : 0);
    check({nm, "_finish_rdy"}, {31'd0, fin_rdy}, {31'd0, is_rd});
    check({nm, "_finish_rd"}, {16'd0, fin_rd}, {16'd0, exp_rd});
    if (chk_tog) check({nm, "_mdc_toggle"}, notog, 0);
    @(negedge clk);
    check({nm, "_rdy_after"}, {31'd0, s_rdy}, 32'd0);
    check({nm, "_rd_after"}, {16'd0, s_rd}, {16'd0, exp_rd});
  endtask

  task automatic invalid_req(input string nm, input logic [31:0] td);
    set_start(1'b1, td);
    @(negedge clk);
    set_start(1'b0, td);
    check({nm, "_err"}, {31'd0, s_err}, 32'd1);
    check({nm, "_busy"}, {31'd0, s_busy}, 32'd0);
    check({nm, "_mdc_oe"}, {30'd0, s_mdc, s_oe}, 32'd0);
    check({nm, "_rdy"}, {31'd0, s_rdy}, 32'd0);
    @(negedge clk);
    check({nm, "_err_after"}, {31'd0, s_err}, 32'd0);
    check({nm, "_busy_after"}, {31'd0, s_busy}, 32'd0);
  endtask

  initial begin
    int rises;
    bit prev_mdc;
    b0.MDIO_START = 0; b0.T_DATA = '0; b0.MDIO_IN = 0;
    b1.MDIO_START = 0; b1.T_DATA = '0; b1.MDIO_IN = 0;
    RESET = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, b0.BUSY}, 32'd0);
    check("rst_pad", {29'd0, b0.MDC, b0.MDIO_OE, b0.MDIO_OUT}, 32'd0);
    check("rst_flags", {30'd0, b0.DATA_RDY, b0.ERR}, 32'd0);
    check("rst_rd", {16'd0, b0.RD_DATA}, 32'd0);
    check("rst_busy_d1", {31'd0, b1.BUSY}, 32'd0);
    RESET = 1'b1;
    @(negedge clk);

    run_frame("c22wr", 32'h508A_ABCD, 16'h0000, 32, 256, 0, 16'h0000, 0);
    run_frame("c22rd", 32'h608A_0000, 16'hBEEF, 32, 256, 1, 16'hBEEF, 0);
    run_frame("c45rd", 32'h3186_0000, 16'h1234, 32, 256, 1, 16'h1234, 0);
    run_frame("c45ad", 32'h0186_0005, 16'hFFFF, 32, 256, 0, 16'h1234, 0);

    invalid_req("inv_st11", 32'hC000_0000);
    invalid_req("inv_op11", 32'h7000_0000);
    check("inv_rd_kept", {16'd0, b0.RD_DATA}, 32'h0000_1234);

    // Restart attempt mid-read, then asynchronous abort.
    set_start(1'b1, 32'h608A_0000);
    @(negedge clk);
    set_start(1'b0, 32'h608A_0000);
    rises = 0;
    prev_mdc = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c > 1 && !prev_mdc && b0.MDC) rises++;
      prev_mdc = b0.MDC;
      if (!b0.BUSY) check("restart_busy_drop", c, 0);
      if (c == 50) set_start(1'b1, 32'h508A_ABCD);
      if (c == 51) set_start(1'b0, 32'h508A_ABCD);
      if (c < 100) @(negedge clk);
    end
    check("restart_mdc_phase", {31'd0, b0.MDC}, 32'd1);
    check("restart_rises", rises, 25);
    RESET = 1'b0;
    #1;
    check("abort_busy", {31'd0, b0.BUSY}, 32'd0);
    check("abort_pad", {29'd0, b0.MDC, b0.MDIO_OE, b0.MDIO_OUT}, 32'd0);
    check("abort_flags", {30'd0, b0.DATA_RDY, b0.ERR}, 32'd0);
    check("abort_rd", {16'd0, b0.RD_DATA}, 32'd0);
    @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    run_frame("post_rst", 32'h508A_ABCD, 16'h0000, 32, 256, 0, 16'h0000, 0);

    sel = 1'b1;
    @(negedge clk);
    run_frame("d1_c22wr", 32'h508A_ABCD, 16'h0000, 0, 64, 0, 16'h0000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mdio_master_param.md
Name: mdio_master_param

Overview:
- Parametrised MDIO management master: next generation of the team's fixed MDIO block.
- Serialises a 32-bit management frame onto MDIO, generates MDC from a configurable clk divider, and inserts a configurable preamble.
- Supports both Clause 22 and Clause 45 frame types, flags unsupported frames, and returns read data with a ready pulse.
- Sits between the host/register interface and the external PHY MDIO pad (tri-state controlled by MDIO_OE).

Parameters:
CLK_DIV, 4, clk cycles per MDC half-period; legal range >=1.
PRE_LEN, 32, preamble length in bits (all ones); legal range 0..32.

Ports:
clk  input  1  system clock; all logic on rising edge.
RESET  input  1  asynchronous, active-low reset.
MDIO_START  input  1  start request; sampled only while idle.
T_DATA  input  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD/PRTAD, [22:18] REGAD/DEVAD, [17:16] TA, [15:0] data/address.
MDIO_IN  input  1  MDIO pad input, driven by the PHY during read turnaround and data.
MDIO_OUT  output  1  serial data to the pad.
MDIO_OE  output  1  pad output enable; 1 = master drives.
MDC  output  1  management clock; low when idle.
RD_DATA  output  16  last read data; holds until the next read completes.
DATA_RDY  output  1  one-clk pulse when a read frame completes.
BUSY  output  1  high while a frame is in progress.
ERR  output  1  one-clk pulse when an unsupported frame is requested.

Behaviour:
- Reset (RESET=0, asynchronous): all outputs 0, FSM to IDLE, counters cleared. Reset mid-frame aborts immediately; MDIO_OE drops in the same cycle reset asserts.
- Frame classification at start:
  - ST=01 with OP=01 is a C22 write; ST=01 with OP=10 is a C22 read.
  - ST=00 with OP=00 (address) or OP=01 (write) is a C45 write-type frame.
  - ST=00 with OP=10 (read-inc) or OP=11 (read) is a C45 read-type frame.
  - Anything else is invalid.
- FSM states: IDLE, PRE, FRAME, FINISH.
  - IDLE: on MDIO_START=1, latch T_DATA.
    - Invalid frame: ERR=1 for the next cycle, stay in IDLE, BUSY stays 0.
    - Valid frame: next cycle BUSY=1, MDIO_OE=1, MDC=0; go to PRE, or straight to FRAME if PRE_LEN=0.
  - PRE: MDIO_OUT=1 for PRE_LEN bit periods.
  - FRAME: bits T_DATA[31] down to [0], MSB first, 5-bit index counter.
  - FINISH: single cycle. MDC=0, MDIO_OE=0, BUSY=0; for reads, DATA_RDY=1 and RD_DATA updated in this cycle. Then return to IDLE.
- Bit period: 2*CLK_DIV clk cycles.
  - MDC low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MDIO_OUT changes only when MDC transitions 1->0, or at frame start, so it is stable across the MDC rising edge.
- Write frames: MDIO_OE=1 for all PRE_LEN+32 bits; TA driven as T_DATA[17:16].
- Read frames:
  - MDIO_OE=1 through bit 18.
  - MDIO_OE=0 from the start of bit 17 (TA) to the end of the frame; MDIO_OUT=0 while released.
  - MDIO_IN is sampled on the clk edge where MDC goes 0->1, for bits 15..0, shifting MSB first.
- Latency: BUSY stays high for exactly (PRE_LEN+32)*2*CLK_DIV cycles, from the cycle after start to FINISH.
- While BUSY=1, MDIO_START is ignored with no queueing; T_DATA changes have no effect.
- RD_DATA is unchanged by write frames, invalid requests and aborted reads.
- DATA_RDY and ERR never assert in the same cycle.

Test Plan:
1. CLK_DIV=2, PRE_LEN=32; C22 write, T_DATA=32'h508A_ABCD.
   -> BUSY high for 256 cycles; MDIO_OE=1 throughout; 32 ones, then 0101_0000_1000_1010_1010_1011_1100_1101 at MDC rises; DATA_RDY never pulses; RD_DATA stays 0.
2. C22 read, T_DATA=32'h608A_0000; bench PHY drives 16'hBEEF on bits 15..0.
   -> MDIO_OE falls at the start of bit 17; DATA_RDY one pulse when BUSY falls; RD_DATA=16'hBEEF.
3. C45 read, T_DATA=32'h3186_0000; PHY returns 16'h1234.
   -> RD_DATA=16'h1234, DATA_RDY pulse. Then C45 address frame 32'h0186_0005 -> no DATA_RDY; RD_DATA stays 16'h1234.
4. Invalid request T_DATA=32'hC000_0000 (ST=11), and T_DATA=32'h7000_0000 (ST=01, OP=11).
   -> ERR one-cycle pulse each; BUSY, MDC and MDIO_OE stay 0.
5. MDIO_START re-pulsed at cycle 50 of a running read, then RESET=0 at cycle 100.
   -> restart ignored; on reset all outputs 0 immediately. Next start produces a normal full 256-cycle frame.
6. Instance with CLK_DIV=1, PRE_LEN=0; C22 write 32'h508A_ABCD.
   -> BUSY for 64 cycles; MDC toggles every clk; first bit driven is 0 (ST[1]).
